muladdsub_seq: RTL and testbench
================================

// Module: muladdsub_seq
// PURPOSE
//  Streaming front/back end for the muladdsub primitive. Accepts operand sets on a valid/ready
//  port, generates the primitive's CE0/CE1/CE2 stage enables, tracks per-stage occupancy and
//  returns SUM = A0*B0 +/- A1*B1 with a tag on a valid/ready result port.
//  Sits between datapath stream logic and one muladdsub instance.
// PARAMETERS
//  OP_W    36  operand width (A0/A1/B0/B1)
//  SUM_W   73  SUM width driven by muladdsub
//  TAG_W   8   user tag carried alongside each operand set
// PORTS
//  CLK0       in   1      clock
//  RST0       in   1      reset, asynchronous, active-high
//  flush      in   1      sync: drop all in-flight entries
//  in_valid   in   1      operand set valid
//  in_ready   out  1      operand set accepted when in_valid&in_ready
//  in_a0/in_b0/in_a1/in_b1  in  OP_W  operands
//  in_sub     in   1      1: A0*B0-A1*B1, 0: add
//  in_tag     in   TAG_W  user tag
//  CE0/CE1/CE2 out 1      muladdsub stage enables
//  ADDNSUB    out  1      to muladdsub, 1=add (inverse of stage-1 in_sub)
//  A0/B0/A1/B1 out OP_W   to muladdsub, combinational copy of in_* operands
//  SUM        in   SUM_W  from muladdsub
//  out_valid  out  1      result valid
//  out_ready  in   1      result accepted when out_valid&out_ready
//  out_sum    out  SUM_W  result
//  out_tag    out  TAG_W  tag of result
//  in_flight  out  3      occupied stages (0..3, 0..5 with skid)
// BEHAVIOUR
//  Occupancy bits v0,v1,v2 mirror primitive stages 0/1/2; sideband regs (sub,tag) shadow each.
//  Bubble-collapsing enables:
//   CE2 = v1 & (~v2 | drain); drain = out_ready (no skid)
//   CE1 = v0 & (~v1 | CE2);  in_ready = ~v0 | CE1;  CE0 = in_valid & in_ready
//  vN <= CEN ? 1 : (CE(N+1) ? 0 : vN); v2 clears on drain without CE2.
//  Primitive samples ADDNSUB at CE2 edge; block drives ADDNSUB = ~sub1 (stage-1 shadow).
//  Latency: accept edge -> out_valid after 3 edges when unstalled; throughput 1/cycle.
//  out_valid = v2, out_sum = SUM, out_tag = tag2. Arithmetic fully in primitive; sub wraps mod 2^SUM_W.
//  Stall: out_ready=0 with v2=1 -> CE2=0, upstream stages fill, then in_ready=0; SUM held.
//  Simultaneous accept+drain with full pipe: all CEs high, no bubble.
//  flush: v*<=0 next edge, CE0 forced 0, in_ready=0 that cycle; primitive contents ignored.
//  Reset (any time, async): v*=0, sideband regs 0, in_ready=0 while RST0, out_valid=0,
//   CE0/1/2=0, in_flight=0. First accept possible on first edge after RST0 falls.
//  in_flight = v0+v1+v2 (+skid count), registered-equivalent of occupancy bits.
// CONFIGURATION
//  MULADDSUB_SKID_EN defined: 2-entry output buffer (sum,tag) after stage 2; out_* from buffer;
//   drain = ~buf_full (registered), removing combinational out_ready->in_ready path; latency 4.
//   Undefined: no buffer, drain = out_ready, latency 3, combinational out_ready->CE chain.
// STRUCTURE
//  Package muladdsub_pkg: OP_W/SUM_W/TAG_W defaults, stage count localparam (3), sideband
//   struct {sub,tag}. Sub-module muladdsub_skid (2-entry buffer) only under MULADDSUB_SKID_EN.
// TESTING
//  1 a0=2,b0=3,a1=3,b1=3,sub=0,tag=1 -> out_sum=15,tag=1, 3 edges after accept (4 w/ skid).
//  2 same operands sub=1 -> out_sum=-3 (73'h1FFFFFFFFFFFFFFFFFD); ADDNSUB=0 at CE2 edge.
//  3 100 back-to-back sets a0=b0=i,a1=b1=i+1, out_ready=1 -> one result/cycle, -(2i+1) with sub=1, tags in order.
//  4 out_ready=0, in_valid=1 -> exactly 3 accepts (5 w/ skid), then in_ready=0; release -> no loss/dup.
//  5 RST0 pulse with pipe full -> out_valid,CE*,in_flight=0 immediately; next result is post-reset set.
//  6 flush with 2 in flight, out_ready=1 -> no out_valid for flushed tags; next set correct.

Source files
------------

// File: rtl/muladdsub_pkg.sv
// Shared widths, sideband/result payloads and helpers for the muladdsub stream wrapper.
// Optional output skid buffer is enabled by defining MULADDSUB_SKID_EN.
package muladdsub_pkg;

  localparam int unsigned OP_W       = 36;
  localparam int unsigned SUM_W      = 73;
  localparam int unsigned TAG_W      = 8;
  localparam int unsigned N_STAGES   = 3;
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = 2;
  localparam int unsigned CNT_W      = 3;

  typedef logic [OP_W-1:0]  op_t;
  typedef logic [SUM_W-1:0] sum_t;
  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic sub;
    tag_t tag;
  } side_t;

  typedef struct packed {
    sum_t sum;
    tag_t tag;
  } result_t;

  // Number of occupied primitive stages.
  function automatic logic [CNT_W-1:0] stage_count(input logic v0, input logic v1, input logic v2);
    return CNT_W'(v0) + CNT_W'(v1) + CNT_W'(v2);
  endfunction

endpackage

// File: rtl/muladdsub_seq_if.sv
// Operand and result stream bundle for muladdsub_seq.
// master = stream source/sink side, slave = muladdsub_seq.
interface muladdsub_seq_if;
  import muladdsub_pkg::*;

  logic in_valid;
  logic in_ready;
  op_t  in_a0;
  op_t  in_b0;
  op_t  in_a1;
  op_t  in_b1;
  logic in_sub;
  tag_t in_tag;

  logic out_valid;
  logic out_ready;
  sum_t out_sum;
  tag_t out_tag;

  modport master (
    output in_valid, in_a0, in_b0, in_a1, in_b1, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_tag
  );

  modport slave (
    input  in_valid, in_a0, in_b0, in_a1, in_b1, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_tag
  );

endinterface

// File: rtl/muladdsub_skid.sv
// Two-entry result buffer behind primitive stage 2 (built only with MULADDSUB_SKID_EN).
// full is derived from the registered count so upstream enables never see out_ready.
`ifdef MULADDSUB_SKID_EN
module muladdsub_skid
  import muladdsub_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  result_t               push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  valid,
  output result_t               data,
  output logic [SKID_CNT_W-1:0] count
);

  result_t                 mem [SKID_DEPTH];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [SKID_CNT_W-1:0]   cnt;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (cnt == SKID_CNT_W'(SKID_DEPTH));
  assign valid   = (cnt != '0);
  assign data    = mem[rd_ptr];
  assign count   = cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
      for (int i = 0; i < int'(SKID_DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + SKID_CNT_W'(do_push) - SKID_CNT_W'(do_pop);
    end
  end

endmodule
`endif

// File: rtl/muladdsub_seq.sv
// Stream front/back end for one muladdsub primitive: stage enables, occupancy, tag sideband.
// Define MULADDSUB_SKID_EN to add a 2-entry output buffer (latency 4, no out_ready->in_ready path).
module muladdsub_seq
  import muladdsub_pkg::*;
(
  input  logic             CLK0,
  input  logic             RST0,
  input  logic             flush,
  muladdsub_seq_if.slave   io,
  output logic             CE0,
  output logic             CE1,
  output logic             CE2,
  output logic             ADDNSUB,
  output op_t              A0,
  output op_t              B0,
  output op_t              A1,
  output op_t              B1,
  input  sum_t             SUM,
  output logic [CNT_W-1:0] in_flight
);

  logic  v0;
  logic  v1;
  logic  v2;
  side_t side0;
  side_t side1;
  tag_t  tag2;
  logic  drain;

  assign A0 = io.in_a0;
  assign B0 = io.in_b0;
  assign A1 = io.in_a1;
  assign B1 = io.in_b1;

  // Bubble-collapsing enable chain, stage 2 back to stage 0.
  assign CE2         = v1 & (~v2 | drain);
  assign CE1         = v0 & (~v1 | CE2);
  assign io.in_ready = ~RST0 & ~flush & (~v0 | CE1);
  assign CE0         = io.in_valid & io.in_ready;
  assign ADDNSUB     = ~side1.sub;

  always_ff @(posedge CLK0 or posedge RST0) begin
    if (RST0) begin
      v0    <= 1'b0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      side0 <= '0;
      side1 <= '0;
      tag2  <= '0;
    end else if (flush) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (CE0) begin
        v0    <= 1'b1;
        side0 <= '{sub: io.in_sub, tag: io.in_tag};
      end else if (CE1) begin
        v0 <= 1'b0;
      end

      if (CE1) begin
        v1    <= 1'b1;
        side1 <= side0;
      end else if (CE2) begin
        v1 <= 1'b0;
      end

      if (CE2) begin
        v2   <= 1'b1;
        tag2 <= side1.tag;
      end else if (drain) begin
        v2 <= 1'b0;
      end
    end
  end

`ifdef MULADDSUB_SKID_EN
  logic                  buf_full;
  logic                  buf_valid;
  logic [SKID_CNT_W-1:0] buf_count;
  result_t               buf_data;
  result_t               stage2_res;

  assign stage2_res = '{sum: SUM, tag: tag2};
  assign drain      = ~buf_full;

  muladdsub_skid u_skid (
    .clk       (CLK0),
    .rst       (RST0),
    .flush     (flush),
    .push      (v2 & drain),
    .push_data (stage2_res),
    .pop       (io.out_ready),
    .full      (buf_full),
    .valid     (buf_valid),
    .data      (buf_data),
    .count     (buf_count)
  );

  assign io.out_valid = buf_valid;
  assign io.out_sum   = buf_data.sum;
  assign io.out_tag   = buf_data.tag;
  assign in_flight    = stage_count(v0, v1, v2) + CNT_W'(buf_count);
`else
  assign drain        = io.out_ready;
  assign io.out_valid = v2;
  assign io.out_sum   = SUM;
  assign io.out_tag   = tag2;
  assign in_flight    = stage_count(v0, v1, v2);
`endif

endmodule

// File: tb/tb_muladdsub_seq.sv
// Bench for muladdsub_seq with a behavioural 3-stage muladdsub primitive and a result scoreboard.
module tb_muladdsub_seq;
  import muladdsub_pkg::*;

`ifdef MULADDSUB_SKID_EN
  localparam int LAT   = 4;
  localparam int DEPTH = 5;
`else
  localparam int LAT   = 3;
  localparam int DEPTH = 3;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             CE0, CE1, CE2, ADDNSUB;
  op_t              A0, B0, A1, B1;
  sum_t             SUM;
  logic [CNT_W-1:0] in_flight;

  muladdsub_seq_if io ();

  muladdsub_seq dut (
    .CLK0      (clk),
    .RST0      (rst),
    .flush     (flush),
    .io        (io),
    .CE0       (CE0),
    .CE1       (CE1),
    .CE2       (CE2),
    .ADDNSUB   (ADDNSUB),
    .A0        (A0),
    .B0        (B0),
    .A1        (A1),
    .B1        (B1),
    .SUM       (SUM),
    .in_flight (in_flight)
  );

  always #5 clk = ~clk;

  // Behavioural primitive: operand regs (CE0), products (CE1), sum with ADDNSUB (CE2).
  op_t         r_a0, r_b0, r_a1, r_b1;
  logic [71:0] p0, p1;
  sum_t        sum_r = '0;
  assign SUM = sum_r;
  always @(posedge clk) begin
    if (CE0) begin
      r_a0 <= A0; r_b0 <= B0; r_a1 <= A1; r_b1 <= B1;
    end
    if (CE1) begin
      p0 <= 72'(r_a0) * 72'(r_b0);
      p1 <= 72'(r_a1) * 72'(r_b1);
    end
    if (CE2) sum_r <= ADDNSUB ? (SUM_W'(p0) + SUM_W'(p1)) : (SUM_W'(p0) - SUM_W'(p1));
  end

  result_t sb_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;

  function automatic sum_t model_sum(input op_t a0, input op_t b0, input op_t a1,
                                     input op_t b1, input logic sub);
    sum_t m0, m1;
    m0 = SUM_W'(a0) * SUM_W'(b0);
    m1 = SUM_W'(a1) * SUM_W'(b1);
    return sub ? (m0 - m1) : (m0 + m1);
  endfunction

  // Scoreboard: every output handshake is compared against the oldest expected entry.
  always @(negedge clk) begin
    result_t e;
    if (!rst && io.out_valid && io.out_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got tag %0d sum %h, required no output", io.out_tag, io.out_sum);
      end else begin
        e = sb_q.pop_front();
        if (io.out_sum !== e.sum || io.out_tag !== e.tag) begin
          n_fail++;
          $display("FAIL out_result: got tag %0d sum %h, required tag %0d sum %h",
                   io.out_tag, io.out_sum, e.tag, e.sum);
        end
      end
    end
  end

  task automatic drive(input op_t a0, input op_t b0, input op_t a1, input op_t b1,
                       input logic sub, input tag_t tag);
    io.in_a0 = a0; io.in_b0 = b0; io.in_a1 = a1; io.in_b1 = b1;
    io.in_sub = sub; io.in_tag = tag; io.in_valid = 1'b1;
  endtask

  // Present one set, wait (bounded) for acceptance, record its expected result.
  task automatic send(input op_t a0, input op_t b0, input op_t a1, input op_t b1,
                      input logic sub, input tag_t tag, output int waits);
    drive(a0, b0, a1, b1, sub, tag);
    waits = 0;
    @(negedge clk);
    while (!io.in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (io.in_ready) begin
      sb_q.push_back('{sum: model_sum(a0, b0, a1, b1, sub), tag: tag});
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: tag %0d not accepted in %0d cycles, required acceptance", tag, waits);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while (sb_q.size() != 0 && c < 400) begin
      @(posedge clk);
      c++;
    end
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb_q.size());
    end
  endtask

  // Single set with observation of latency, ADDNSUB during CE2, and the first output.
  task automatic run_single(input op_t a0, input op_t b0, input op_t a1, input op_t b1,
                            input logic sub, input tag_t tag,
                            output int lat, output logic ans, output sum_t s, output tag_t t);
    int w;
    io.out_ready = 1'b1;
    send(a0, b0, a1, b1, sub, tag, w);
    io.in_valid = 1'b0;
    lat = 1;
    ans = 1'bx;
    while (!io.out_valid && lat < 20) begin
      if (CE2) ans = ADDNSUB;
      @(posedge clk);
      #1;
      lat++;
    end
    s = io.out_sum;
    t = io.out_tag;
  endtask

  task automatic test_reset;
    io.in_valid = 1'b1; io.out_ready = 1'b1;
    io.in_a0 = '0; io.in_b0 = '0; io.in_a1 = '0; io.in_b1 = '0; io.in_sub = 1'b0; io.in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (io.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 0", io.in_ready); end
    n_checks++;
    if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", io.out_valid); end
    n_checks++;
    if ({CE0, CE1, CE2} !== 3'b000) begin n_fail++; $display("FAIL reset_ce: got %b, required 000", {CE0, CE1, CE2}); end
    n_checks++;
    if (in_flight !== '0) begin n_fail++; $display("FAIL reset_in_flight: got %0d, required 0", in_flight); end
    @(negedge clk);
    io.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b, required 1", io.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add;
    int lat; logic ans; sum_t s; tag_t t;
    run_single(36'd2, 36'd3, 36'd3, 36'd3, 1'b0, 8'd1, lat, ans, s, t);
    n_checks++;
    if (lat != LAT) begin n_fail++; $display("FAIL add_latency: got %0d edges, required %0d", lat, LAT); end
    n_checks++;
    if (s !== SUM_W'(15) || t !== 8'd1) begin n_fail++; $display("FAIL add_result: got sum %0d tag %0d, required 15 tag 1", s, t); end
    n_checks++;
    if (ans !== 1'b1) begin n_fail++; $display("FAIL add_addnsub: got %b, required 1", ans); end
    wait_drain("add");
  endtask

  task automatic test_sub;
    int lat; logic ans; sum_t s; tag_t t;
    run_single(36'd2, 36'd3, 36'd3, 36'd3, 1'b1, 8'd2, lat, ans, s, t);
    n_checks++;
    if (lat != LAT) begin n_fail++; $display("FAIL sub_latency: got %0d edges, required %0d", lat, LAT); end
    n_checks++;
    if (s !== 73'h1FFFFFFFFFFFFFFFFFD || t !== 8'd2) begin
      n_fail++; $display("FAIL sub_result: got sum %h tag %0d, required 1fffffffffffffffffd tag 2", s, t);
    end
    n_checks++;
    if (ans !== 1'b0) begin n_fail++; $display("FAIL sub_addnsub: got %b, required 0", ans); end
    wait_drain("sub");
  endtask

  task automatic test_back_to_back;
    int stalls = 0;
    int w;
    io.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(op_t'(i), op_t'(i), op_t'(i + 1), op_t'(i + 1), 1'b1, tag_t'(i));
      w = 0;
      @(negedge clk);
      while (!io.in_ready && w < 50) begin @(negedge clk); w++; end
      stalls += w;
      sb_q.push_back('{sum: SUM_W'(0) - SUM_W'(2 * i + 1), tag: tag_t'(i)});
      @(posedge clk);
      #1;
    end
    io.in_valid = 1'b0;
    n_checks++;
    if (stalls != 0) begin n_fail++; $display("FAIL b2b_stalls: got %0d stall cycles, required 0", stalls); end
    wait_drain("b2b");
  endtask

  task automatic test_stall;
    int accepts = 0;
    int k = 0;
    io.out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive(op_t'(k + 1), 36'd5, op_t'(k), 36'd7, 1'(k % 2), tag_t'(50 + k));
      @(negedge clk);
      if (io.in_ready) begin
        sb_q.push_back('{sum: model_sum(op_t'(k + 1), 36'd5, op_t'(k), 36'd7, 1'(k % 2)), tag: tag_t'(50 + k)});
        accepts++;
        k++;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (accepts != DEPTH) begin n_fail++; $display("FAIL stall_accepts: got %0d, required %0d", accepts, DEPTH); end
    n_checks++;
    if (io.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b, required 0", io.in_ready); end
    n_checks++;
    if (in_flight !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL stall_in_flight: got %0d, required %0d", in_flight, DEPTH); end
    n_checks++;
    if (io.out_valid !== 1'b1 || io.out_sum !== sb_q[0].sum) begin
      n_fail++; $display("FAIL stall_held: got valid %b sum %h, required valid 1 sum %h", io.out_valid, io.out_sum, sb_q[0].sum);
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_reset_full;
    int w;
    io.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(op_t'(i + 9), 36'd2, 36'd1, 36'd1, 1'b0, tag_t'(80 + i), w);
    drive(36'd1, 36'd1, 36'd1, 36'd1, 1'b0, 8'd99);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_out_valid: got %b, required 0", io.out_valid); end
    n_checks++;
    if ({CE0, CE1, CE2} !== 3'b000) begin n_fail++; $display("FAIL rstfull_ce: got %b, required 000", {CE0, CE1, CE2}); end
    n_checks++;
    if (in_flight !== '0) begin n_fail++; $display("FAIL rstfull_in_flight: got %0d, required 0", in_flight); end
    sb_q.delete();
    io.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(36'd7, 36'd9, 36'd4, 36'd4, 1'b1, 8'hA5, w);
    io.in_valid = 1'b0;
    wait_drain("rstfull");
  endtask

  task automatic test_flush;
    int w;
    io.out_ready = 1'b1;
    send(36'd1, 36'd1, 36'd1, 36'd1, 1'b0, 8'h11, w);
    send(36'd2, 36'd2, 36'd2, 36'd2, 1'b0, 8'h12, w);
    drive(36'd9, 36'd9, 36'd9, 36'd9, 1'b0, 8'h13);
    flush = 1'b1;
    #1;
    n_checks++;
    if (in_flight !== CNT_W'(2)) begin n_fail++; $display("FAIL flush_in_flight_before: got %0d, required 2", in_flight); end
    n_checks++;
    if (io.in_ready !== 1'b0 || CE0 !== 1'b0) begin
      n_fail++; $display("FAIL flush_block: got in_ready %b CE0 %b, required 0 0", io.in_ready, CE0);
    end
    sb_q.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    io.in_valid = 1'b0;
    n_checks++;
    if (in_flight !== '0) begin n_fail++; $display("FAIL flush_in_flight_after: got %0d, required 0", in_flight); end
    repeat (6) @(posedge clk);
    #1;
    send(36'd3, 36'd4, 36'd5, 36'd6, 1'b1, 8'h21, w);
    io.in_valid = 1'b0;
    wait_drain("flush");
  endtask

  task automatic test_random_backpressure;
    bit done = 1'b0;
    fork
      begin
        int w;
        for (int i = 0; i < 40; i++)
          send(op_t'({$urandom(), $urandom()}), op_t'({$urandom(), $urandom()}),
               op_t'({$urandom(), $urandom()}), op_t'({$urandom(), $urandom()}),
               1'($urandom_range(0, 1)), tag_t'(120 + i), w);
        io.in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        int c = 0;
        while (!done && c < 5000) begin
          @(posedge clk);
          #1;
          io.out_ready = 1'($urandom_range(0, 1));
          c++;
        end
      end
    join
    io.out_ready = 1'b1;
    wait_drain("random");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_full();
    test_flush();
    test_random_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
